// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the CSR access unit.
//   - funct3 encodings of the CSR instruction family
//   - sequencer state encoding
//   - CSR address width and the read-only address field value
package csr_pkg;

  localparam int CSR_AW = 12;

  // Top two address bits equal to this value mark a read-only CSR.
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_t;

  // True when the two top address bits select the read-only CSR space.
  function automatic logic csr_is_ro(input logic [1:0] addr_field);
    return (addr_field == CSR_RO_FIELD);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational new-value computation for one CSR instruction.
// Ports:
//   funct3       in   instruction funct3
//   old_val      in   current CSR value
//   src_val      in   rs1 value or zero-extended uimm
//   src_zero     in   rs1 index / uimm field is zero
//   new_val      out  value to write back
//   write_needed out  instruction performs a CSR write
//   illegal      out  funct3 does not encode a CSR operation
// The read-only address check is applied by the caller, which owns the address.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src_val,
  input  logic            src_zero,
  output logic [XLEN-1:0] new_val,
  output logic            write_needed,
  output logic            illegal
);

  // Decode funct3 into the bitwise operation and its write requirement.
  always_comb begin
    new_val      = {XLEN{1'b0}};
    write_needed = 1'b0;
    illegal      = 1'b0;
    case (funct3)
      CSR_RW, CSR_RWI: begin
        new_val      = src_val;
        write_needed = 1'b1;
      end
      // Set/clear with a zero source is a pure read and must not write.
      CSR_RS, CSR_RSI: begin
        new_val      = old_val | src_val;
        write_needed = ~src_zero;
      end
      CSR_RC, CSR_RCI: begin
        new_val      = old_val & ~src_val;
        write_needed = ~src_zero;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one CSR instruction at a time against the
// single read/write port of the CSR file (IDLE -> READ -> [WRITE] -> RESP).
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake from execute
//   req_funct3/addr/src/src_zero instruction fields
//   resp_valid/resp_ready       response handshake to the pipeline
//   resp_rdata/resp_illegal     old CSR value / illegal-instruction flag
//   csr_addr/csr_wdata/csr_w_enable/csr_rdata  CSR file port
// All outputs are registered; csr_rdata is combinational from csr_addr.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = csr_pkg::CSR_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [CSR_AW-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_src_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_w_enable,
  input  logic [XLEN-1:0]   csr_rdata
);
  import csr_pkg::*;

  csr_state_t        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic              src_zero_q, src_zero_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_illegal_q, resp_illegal_d;
  logic [CSR_AW-1:0] csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              csr_w_enable_q, csr_w_enable_d;

  logic [XLEN-1:0]   alu_new_s;
  logic              alu_write_needed_s;
  logic              alu_illegal_s;
  logic              illegal_s;

  // csr_addr_q holds the latched address throughout READ, so csr_rdata is the old value.
  csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3       (funct3_q),
    .old_val      (csr_rdata),
    .src_val      (src_q),
    .src_zero     (src_zero_q),
    .new_val      (alu_new_s),
    .write_needed (alu_write_needed_s),
    .illegal      (alu_illegal_s)
  );

  // Illegal on a bad funct3 or on any write attempt into read-only CSR space.
  assign illegal_s = alu_illegal_s |
                     (alu_write_needed_s & csr_is_ro(csr_addr_q[CSR_AW-1 -: 2]));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    src_d          = src_q;
    src_zero_d     = src_zero_q;
    old_d          = old_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    csr_addr_d     = csr_addr_q;
    csr_wdata_d    = csr_wdata_q;
    csr_w_enable_d = csr_w_enable_q;
    case (state_q)
      ST_IDLE: begin
        // Address is registered at accept so it is already on the port in READ.
        if (req_valid && req_ready_q) begin
          state_d    = ST_READ;
          funct3_d   = req_funct3;
          src_d      = req_src;
          src_zero_d = req_src_zero;
          csr_addr_d = req_addr;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        old_d = csr_rdata;
        if (alu_write_needed_s && !illegal_s) begin
          state_d        = ST_WRITE;
          csr_wdata_d    = alu_new_s;
          csr_w_enable_d = 1'b1;
        end else begin
          state_d        = ST_RESP;
          csr_addr_d     = {CSR_AW{1'b0}};
          resp_valid_d   = 1'b1;
          resp_rdata_d   = illegal_s ? {XLEN{1'b0}} : csr_rdata;
          resp_illegal_d = illegal_s;
        end
      end
      ST_WRITE: begin
        state_d        = ST_RESP;
        csr_addr_d     = {CSR_AW{1'b0}};
        csr_wdata_d    = {XLEN{1'b0}};
        csr_w_enable_d = 1'b0;
        resp_valid_d   = 1'b1;
        resp_rdata_d   = old_q;
        resp_illegal_d = 1'b0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d        = ST_IDLE;
          resp_valid_d   = 1'b0;
          resp_rdata_d   = {XLEN{1'b0}};
          resp_illegal_d = 1'b0;
        end else begin
          state_d        = ST_RESP;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = {XLEN{1'b0}};
        resp_illegal_d = 1'b0;
        csr_addr_d     = {CSR_AW{1'b0}};
        csr_wdata_d    = {XLEN{1'b0}};
        csr_w_enable_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset clears everything, aborting any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      funct3_q       <= 3'b000;
      src_q          <= {XLEN{1'b0}};
      src_zero_q     <= 1'b0;
      old_q          <= {XLEN{1'b0}};
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= {XLEN{1'b0}};
      resp_illegal_q <= 1'b0;
      csr_addr_q     <= {CSR_AW{1'b0}};
      csr_wdata_q    <= {XLEN{1'b0}};
      csr_w_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      src_q          <= src_d;
      src_zero_q     <= src_zero_d;
      old_q          <= old_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
      csr_addr_q     <= csr_addr_d;
      csr_wdata_q    <= csr_wdata_d;
      csr_w_enable_q <= csr_w_enable_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
  assign csr_addr     = csr_addr_q;
  assign csr_wdata    = csr_wdata_q;
  assign csr_w_enable = csr_w_enable_q;

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

CSR instruction sequencer for the core: the requesting end of the CSR register file's single read/write port. It accepts one CSR instruction (CSRRW/CSRRS/CSRRC and their immediate forms) from the execute stage and reads the old value from the CSR file. It then computes the new value, writes it back when the instruction requires a write, and returns the old value (or an illegal-instruction flag) to the pipeline over a valid/ready response channel. One request is in flight at a time.

## Interface
Parameters:
- XLEN, 32, data width of CSRs and operands
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  1  CSR instruction request
- req_ready  out  1  unit idle, request accepted on valid&&ready
- req_funct3  in  3  instruction funct3
- req_addr  in  CSR_AW  CSR address (inst[31:20])
- req_src  in  XLEN  rs1 value, or zero-extended 5-bit uimm for I-forms
- req_src_zero  in  1  rs1 index / uimm field is zero
- resp_valid  out  1  result available
- resp_ready  in  1  pipeline accepts result
- resp_rdata  out  XLEN  old CSR value destined for rd
- resp_illegal  out  1  request raised illegal instruction
- csr_addr  out  CSR_AW  CSR file address
- csr_wdata  out  XLEN  CSR file write data
- csr_w_enable  out  1  CSR file write strobe
- csr_rdata  in  XLEN  CSR file read data, combinational from csr_addr

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch funct3, addr, src and src_zero, then go to READ.
- READ: drive csr_addr=latched addr and capture csr_rdata into old_q. Compute new_q, write_needed and illegal.
  - If write_needed && !illegal, go to WRITE; otherwise go to RESP.
- WRITE: csr_w_enable=1 for exactly one cycle, with csr_addr=addr and csr_wdata=new_q. Then go to RESP.
- RESP: resp_valid=1. Hold resp_rdata and resp_illegal stable until resp_ready, then go to IDLE.
- Operations:
  - funct3 001/101 (RW/RWI): new = src
  - funct3 010/110 (RS/RSI): new = old | src
  - funct3 011/111 (RC/RCI): new = old & ~src
- write_needed = 1 for RW/RWI. For RS/RC/RSI/RCI it is !src_zero.
- illegal is set when either condition holds:
  - funct3 is 000 or 100
  - write_needed && addr[11:10]==2'b11 (read-only CSR)
- When illegal: no write, resp_rdata=0, resp_illegal=1.
- A read of a read-only CSR with no write (e.g. CSRRS with x0) is legal.
- csr_addr, csr_wdata and csr_w_enable are 0 in IDLE and RESP. csr_w_enable is 1 only in WRITE.
- Arithmetic is bitwise at XLEN. Immediates arrive already zero-extended, and the unit does not re-extend.

## Timing
- Reset (async assert, sync-released use on next edge): state=IDLE and all outputs 0. req_ready is forced 0 while rst is high and becomes 1 on the first cycle after deassertion.
- Request accepted at edge N → READ in cycle N+1 → WRITE in N+2 (if any) → resp_valid in N+3 with a write, or N+2 without one.
- CSR file write takes effect at the edge ending the WRITE cycle. A request accepted afterwards reads the new value.
- Back-to-back rate: one instruction per 3 cycles (no write) or 4 cycles (write) with resp_ready held high. The accept edge is the cycle after the RESP handshake, and req_ready is low during READ/WRITE/RESP.
- Response backpressure: resp_valid stays high and outputs stay stable indefinitely. No new request is accepted.
- Reset mid-operation (READ/WRITE/RESP): the unit aborts immediately. Any in-progress write strobe drops asynchronously and the response is discarded.

## Structure
- Shared package csr_pkg holds:
  - funct3 constants (CSR_RW=3'b001, CSR_RS=3'b010, CSR_RC=3'b011, CSR_RWI=3'b101, CSR_RSI=3'b110, CSR_RCI=3'b111)
  - state encoding (IDLE/READ/WRITE/RESP)
  - CSR_AW and the read-only address field constant 2'b11
- One combinational sub-module, csr_alu. Inputs: funct3, old, src, src_zero. Outputs: new, write_needed, illegal.
- The FSM, latches and port muxing live in csr_access_unit.

## Test plan
- CSRRW: csr 0x340 preloaded 0x1234, req_src=0xDEADBEEF → WRITE cycle with wdata 0xDEADBEEF at addr 0x340; resp_rdata=0x1234; resp_valid at N+3.
- CSRRS with rs1=x0 on read-only 0xC00 holding 0x55 → no csr_w_enable pulse; resp_rdata=0x55, resp_illegal=0, resp_valid at N+2.
- CSRRCI uimm=0x3 on 0x300 holding 0xF → wdata 0xC; a follow-up CSRRS x0 read returns 0xC.
- CSRRW to 0xC01, and funct3=100 → resp_illegal=1, resp_rdata=0, csr_w_enable never asserted.
- resp_ready held low 5 cycles → resp_valid and resp_rdata stable, req_ready=0, the second req_valid is not accepted until the handshake.
- rst pulsed during WRITE → csr_w_enable falls immediately with no response issued; req_ready=1 in the first cycle after release.
